// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell (two half adders + OR) reused LSB-first, one bit per cycle.
// One operation in flight; in_ready only in IDLE, DONE holds sum/carry_out until out_ready.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy,
  output logic [7:0]       op_count
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH must be in 2..32");
  end

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [7:0]       op_count_q, op_count_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic fa_sum, fa_carry;

  half_adder u_ha0 (
    .x (a_sh_q[0]),
    .y (b_sh_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  half_adder u_ha1 (
    .x (ha0_s),
    .y (carry_q),
    .s (ha1_s),
    .c (ha1_c)
  );

  assign fa_sum   = ha1_s;
  assign fa_carry = ha0_c | ha1_c;

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    psum_d     = psum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    op_count_d = op_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          psum_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB
        psum_d  = {fa_sum, psum_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum, psum_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      psum_q     <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      psum_q     <= psum_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign op_count  = op_count_q;

endmodule

// Combinational half adder used twice to form the full-adder cell.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): latency, handshakes, stall, reset abort, wrap.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, carry_out, busy;
  logic [W-1:0] a, b, sum;
  logic [7:0]   op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int lat;
  int extra;

  logic [8:0] exp_q[$];
  int acc, got, last_acc, cyc;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands in an IDLE cycle and return just after the accepting edge.
  task automatic start_op(input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    chk("accept_in_ready", in_ready, 1);
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges counted including the accepting edge; returns at the negedge out_valid is first seen.
  task automatic wait_done(output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) return;
      @(posedge clk);
      n++;
    end
    chk("done_timeout", out_valid, 1);
  endtask

  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [W-1:0] es, input logic ec);
    int l;
    out_ready = 1'b1;
    start_op(aa, bb);
    wait_done(l);
    chk("latency", l, W + 1);
    chk("sum", sum, es);
    chk("carry_out", carry_out, ec);
    chk("done_in_ready", in_ready, 0);
    chk("done_busy", busy, 1);
    @(posedge clk);
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("post_out_valid", out_valid, 0);
    chk("post_op_count", op_count, exp_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_op_count", op_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    run_op(8'h00, 8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1);
    run_op(8'hA5, 8'h5A, 8'hFF, 1'b0);
    run_op(8'h80, 8'h80, 8'h00, 1'b1);
    run_op(8'h7F, 8'h01, 8'h80, 1'b0);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1);
    run_op(8'h3C, 8'h0F, 8'h4B, 1'b0);

    // Stall in DONE, with a new request pending that must wait for IDLE.
    out_ready = 1'b0;
    start_op(8'h12, 8'h34);
    wait_done(lat);
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_sum", sum, 8'h46);
      chk("stall_carry", carry_out, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_op_count", op_count, exp_cnt);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    chk("release_out_valid", out_valid, 0);
    chk("release_busy", busy, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_sum_hold", sum, 8'h46);
    chk("release_op_count", op_count, exp_cnt);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat);
    chk("pending_lat", lat, W + 1);
    chk("pending_sum", sum, 8'h03);
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    chk("pending_op_count", op_count, exp_cnt);

    // Reset in the 4th RUN cycle abandons the operation.
    start_op(8'h7F, 8'h01);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_carry", carry_out, 0);
    chk("abort_op_count", op_count, 0);
    exp_cnt = 0;
    rst_n = 1'b1;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("abort_no_result", extra, 0);

    // Operand/in_valid churn during RUN must not disturb the captured pair.
    start_op(8'hC8, 8'h64);
    for (int k = 0; k < W - 1; k++) begin
      @(negedge clk);
      in_valid = k[0];
      a = 8'($urandom);
      b = 8'($urandom);
      if (in_ready) extra++;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    chk("churn_in_ready", extra, 0);
    wait_done(lat);
    chk("churn_sum", sum, 8'h2C);
    chk("churn_carry", carry_out, 1);
    @(posedge clk);
    exp_cnt++;
    extra = 0;
    repeat (2 * W + 4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("churn_no_extra", extra, 0);
    chk("churn_op_count", op_count, exp_cnt);

    // Reset, then 256 back-to-back operations to wrap op_count.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    acc = 0; got = 0; last_acc = 0; cyc = 0;
    while (got < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("b2b_result", {carry_out, sum}, exp_q.pop_front());
        if (got == 255) chk("b2b_count_255", op_count, 255);
        got++;
      end
      if (in_ready && acc < 256) begin
        a = W'(acc * 37 + 5);
        b = W'(acc * 91 + 3);
        in_valid = 1'b1;
        exp_q.push_back({1'b0, a} + {1'b0, b});
        if (acc > 0) chk("b2b_interval", cyc - last_acc, 10);
        last_acc = cyc;
        acc++;
      end else if (acc >= 256) begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_all_done", got, 256);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_wrap", op_count, 0);
    chk("b2b_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand width in bits; legal range is 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 out_valid  output  1  sum/carry_out hold a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 sum  output  WIDTH  registered result, a+b modulo 2^WIDTH.
REQ-011 carry_out  output  1  registered carry out of bit WIDTH-1.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 op_count  output  8  count of completed results, wrapping.

Function
REQ-014 The datapath SHALL be a single 1-bit full-adder cell built from two half_adder instances plus an OR gate, reused once per bit.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; when in_valid=1, capture a and b into internal shift registers, clear the internal carry, clear the bit counter, and go to RUN.
REQ-017 RUN: each cycle, add bit 0 of each shift register plus the internal carry, shift the result bit in at the MSB of the partial sum, shift both operands right, update the carry, and increment the bit counter.
REQ-018 RUN SHALL last exactly WIDTH cycles; on the cycle the counter equals WIDTH-1, the next state is DONE.
REQ-019 On entry to DONE, sum and carry_out SHALL load the final partial sum and carry in the same edge; out_valid=1 throughout DONE.
REQ-020 DONE: on out_valid and out_ready both high, go to IDLE and increment op_count modulo 256 (255 wraps to 0).
REQ-021 Latency: out_valid SHALL rise WIDTH+1 edges after the accepting edge; minimum initiation interval is WIDTH+2 cycles.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid, a and b in those states SHALL have no effect.
REQ-023 Operand changes after the accepting edge SHALL NOT affect the result.
REQ-024 sum and carry_out SHALL hold their value outside DONE, changing only on DONE entry.
REQ-025 If in_valid and out_ready are both high in DONE, the block SHALL go to IDLE only; the new operands are accepted no earlier than the following IDLE cycle.
REQ-026 While out_ready=0 in DONE, all outputs SHALL hold stable indefinitely.

Reset
REQ-027 On rst_n=0 at a rising edge, the following SHALL be cleared: state=IDLE, sum=0, carry_out=0, out_valid=0, busy=0, op_count=0, internal carry=0, bit counter=0, shift registers=0.
REQ-028 in_ready SHALL be 1 from the first edge after reset release.
REQ-029 Reset asserted in RUN or DONE SHALL abandon the operation with no result delivered and op_count not incremented; reset has priority over all handshakes.

Verification
REQ-030 a=8'h00, b=8'h00, out_ready=1 -> out_valid rises 9 edges after accept with sum=8'h00, carry_out=0, op_count=1.
REQ-031 a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1; a=8'hA5, b=8'h5A -> sum=8'hFF, carry_out=0.
REQ-032 out_ready held 0 for 5 cycles in DONE -> sum, carry_out, out_valid stable; in_ready=0; IDLE on the edge after out_ready=1.
REQ-033 rst_n=0 on the 4th RUN cycle of a=8'h7F, b=8'h01 -> next cycle state IDLE, all outputs zero, op_count unchanged at 0.
REQ-034 in_valid toggled with new a/b during RUN -> result equals the originally accepted operands; no extra result produced.
REQ-035 256 back-to-back operations (in_valid=1, out_ready=1) -> op_count wraps to 0; each result matches a+b; interval is exactly 10 cycles.
